serial_complementer: RTL and testbench
======================================

# serial_complementer

Bit-serial one's/two's complement unit, the parametrised sequential successor of the team's 6-bit combinational two's complementer. Accepts a WIDTH-bit word over a valid/ready handshake, processes it LSB-first one bit per clock using the copy-until-first-one rule, and presents the result with zero and overflow flags over a second valid/ready handshake. It is intended for area-constrained datapaths where one complementer is shared serially across wide words.

## Interface
- WIDTH, 6, data word width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data/in_mode valid
- in_ready  out  1  block can accept a word
- in_data  in  WIDTH  operand
- in_mode  in  1  0 = one's complement, 1 = two's complement
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  complemented word
- out_zero  out  1  out_data == 0
- out_ovf  out  1  two's mode and operand == 1 followed by WIDTH-1 zeros (result unrepresentable, equals operand)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, capture in_data into shift register, latch in_mode, clear bit counter and seen_one flag, go SHIFT.
- SHIFT: each cycle consume LSB b of the shift register. Two's mode: result bit = seen_one ? ~b : b, then seen_one |= b. One's mode: result bit = ~b. Result bit shifts into the result register MSB-first, so after WIDTH cycles bit i sits at position i. Counter increments; on count == WIDTH-1 go DONE.
- DONE: out_valid=1; out_data, out_zero, out_ovf stable. On out_ready go IDLE. Held indefinitely under backpressure.
- out_ovf computed during SHIFT: set if two's mode, the single 1 seen is in bit WIDTH-1 and all lower bits are 0.
- out_zero = (result == 0); true for operand 0 in two's mode and all-ones in one's mode.
- in_data/in_mode are ignored outside the accepting edge.
- All arithmetic is modulo 2^WIDTH; no sign extension, no carry-out.

## Timing
- Reset (async assert, sync deassert handled by the reset source): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_zero=0, out_ovf=0, counter=0.
- Reset asserted mid-SHIFT or in DONE: word discarded, no output handshake occurs, block returns to IDLE.
- Latency: accept edge at cycle 0 -> out_valid high from cycle WIDTH.
- Throughput: one word per WIDTH+2 cycles when out_ready is held high (accept, WIDTH shift cycles, DONE handshake cycle, back in IDLE).
- in_ready is low in SHIFT and DONE; no accept during DONE even if out_ready is high in the same cycle.
- All outputs registered or decoded from state register only; no combinational path from in_* or out_ready to any output.

## Structure
- Package complement_pkg: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), MODE_ONES=1'b0, MODE_TWOS=1'b1.
- Optional sub-module complement_bit_cell: combinational one-bit step (b, seen_one, mode -> out_bit, seen_one_next); top holds FSM, counter, shift and result registers, flags.

## Test plan
- WIDTH=6, two's, in_data=000101 -> after 6 cycles out_data=111011, out_zero=0, out_ovf=0.
- WIDTH=6, two's, in_data=000000 -> out_data=000000, out_zero=1; in_data=100000 -> out_data=100000, out_ovf=1.
- WIDTH=6, one's, in_data=101010 -> out_data=010101; in_data=111111 -> out_data=000000, out_zero=1, out_ovf=0.
- Backpressure: out_ready low 10 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout; accept happens only after handshake.
- Reset asserted at SHIFT cycle 3 -> outputs return to reset values immediately; next word 000011 (two's) yields 111101 normally.
- Exhaustive WIDTH=6, both modes, all 64 operands back-to-back with out_ready=1 -> out_data equals ~a+1 (two's) or ~a (one's), each word exactly 8 cycles apart.

Source files
------------

// File: rtl/complement_pkg.sv
// Shared encodings for the bit-serial complementer: FSM states and mode values.
package complement_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ONES = 1'b0;
    localparam logic MODE_TWOS = 1'b1;

endpackage

// File: rtl/complement_bit_cell.sv
// One combinational step of the copy-until-first-one complement rule.
module complement_bit_cell
    import complement_pkg::*;
(
    input  logic b_i,
    input  logic seen_i,
    input  logic mode_i,
    output logic bit_o,
    output logic seen_o
);

    always_comb begin
        if (mode_i == MODE_TWOS) begin
            bit_o = seen_i ? ~b_i : b_i;
        end else begin
            bit_o = ~b_i;
        end
        seen_o = seen_i | b_i;
    end

endmodule

// File: rtl/serial_complementer.sv
// Bit-serial one's/two's complementer: accepts a word, processes it LSB-first
// one bit per clock, then holds the result with zero/overflow flags until taken.
module serial_complementer
    import complement_pkg::*;
#(
    parameter  int WIDTH = 6,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ovf
);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             mode_q, mode_d;
    logic             seen_q, seen_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             res_bit;
    logic             seen_next;

    complement_bit_cell u_cell (
        .b_i    (shift_q[0]),
        .seen_i (seen_q),
        .mode_i (mode_q),
        .bit_o  (res_bit),
        .seen_o (seen_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            res_q   <= '0;
            mode_q  <= MODE_ONES;
            seen_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            seen_q  <= seen_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        res_d   = res_q;
        mode_d  = mode_q;
        seen_d  = seen_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Result enters at the MSB so bit i lands at position i after WIDTH steps.
                shift_d = shift_q >> 1;
                res_d   = {res_bit, res_q[WIDTH-1:1]};
                seen_d  = seen_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    zero_d  = (res_d == '0);
                    // Overflow: the first and only 1 is the MSB in two's mode.
                    ovf_d   = (mode_q == MODE_TWOS) && !seen_q && shift_q[0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_complementer.sv
// Scoreboard bench for serial_complementer at WIDTH=6.
module tb_serial_complementer;

    localparam int W = 6;

    typedef struct packed {
        logic [W-1:0] d;
        logic         z;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_zero;
    logic         out_ovf;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_cyc = -1;
    logic spacing_on = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    serial_complementer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic m);
        exp_t e;
        if (m) e.d = ~a + 6'd1;
        else   e.d = ~a;
        e.z = (e.d == '0);
        e.o = m && (a == 6'b100000);
        return e;
    endfunction

    task automatic send(input logic [W-1:0] d, input logic m);
        int t = 0;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model(d, m));
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_mode  = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare at each output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e.d));
                check("out_zero", 32'(out_zero), 32'(mon_e.z));
                check("out_ovf",  32'(out_ovf),  32'(mon_e.o));
            end
            if (spacing_on) begin
                if (last_cyc >= 0) check("spacing", 32'(cyc - last_cyc), 32'd8);
                last_cyc = cyc;
            end
        end
    end

    initial begin
        int t;
        // Reset state
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        send(6'b000101, 1'b1);
        send(6'b000000, 1'b1);
        send(6'b100000, 1'b1);
        send(6'b101010, 1'b0);
        send(6'b111111, 1'b0);
        drain();

        // Backpressure: hold DONE with a competing word offered
        out_ready = 1'b0;
        send(6'b000101, 1'b1);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 6'b001100;
        in_mode  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'b111011);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_in_done", 32'(in_ready), 32'd0);
        send(6'b001100, 1'b0);
        drain();

        // Reset in the middle of SHIFT
        send(6'b000111, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data",  32'(out_data),  32'd0);
        check("mid_rst_out_zero",  32'(out_zero),  32'd0);
        check("mid_rst_out_ovf",   32'(out_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(6'b000011, 1'b1);
        drain();

        // Exhaustive, back-to-back
        last_cyc   = -1;
        spacing_on = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 64; a++) begin
                send(W'(a), 1'(m));
            end
        end
        drain();
        spacing_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
